mem_arbiter: RTL and testbench

- Shares the single external memory bus (SRAM/flash, fixed multi-cycle access) between two requesters: the instruction-fetch stage and the data-memory stage.
- Registers and holds each access on the bus for a fixed number of cycles, then returns the read data with a one-cycle ack.
- Pipeline stages treat "req high and ack low" as a stall condition.
- The data port has strict priority, because it always belongs to the older instruction.

---
 rtl/mem_arbiter.sv | 113 +++++++++++
 tb/tb_mem_arbiter.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-port memory bus arbiter: data port has strict priority over instruction fetch.
// Each access is held on the bus for WAIT_CYCLES cycles, then acked for one cycle.
module mem_arbiter #(
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ack,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [3:0]  d_be,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_ack,
  output logic        bus_en,
  output logic        bus_we,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  output logic        grant_d
);

  typedef enum logic {IDLE, ACCESS} state_t;

  localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);

  state_t     state, state_nx;
  logic [3:0] cnt;
  logic       d_elig, f_elig;
  logic       grant_now, grant_d_now, done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // A port whose ack is high this cycle is not eligible, so a held req is not re-granted.
  always_comb begin
    d_elig = d_req & ~d_ack;
    f_elig = if_req & ~if_ack;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (d_elig || f_elig) state_nx = ACCESS;
      ACCESS:  if (cnt == '0)        state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    grant_now   = (state == IDLE) && (d_elig || f_elig);
    grant_d_now = d_elig;
    done        = (state == ACCESS) && (cnt == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      bus_en    <= 1'b0;
      bus_we    <= 1'b0;
      bus_be    <= '0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      grant_d   <= 1'b0;
      if_ack    <= 1'b0;
      d_ack     <= 1'b0;
      if_rdata  <= '0;
      d_rdata   <= '0;
    end else begin
      if_ack <= 1'b0;
      d_ack  <= 1'b0;
      if (grant_now) begin
        bus_en  <= 1'b1;
        grant_d <= grant_d_now;
        cnt     <= CNT_INIT;
        if (grant_d_now) begin
          bus_we    <= d_we;
          bus_be    <= d_be;
          bus_addr  <= d_addr;
          bus_wdata <= d_wdata;
        end else begin
          bus_we    <= 1'b0;
          bus_be    <= '1;
          bus_addr  <= if_addr;
          bus_wdata <= '0;
        end
      end else if (state == ACCESS) begin
        if (!done) begin
          cnt <= cnt - 4'd1;
        end else begin
          bus_en <= 1'b0;
          bus_we <= 1'b0;
          // bus_we still holds the direction of the access being completed.
          if (grant_d) begin
            d_ack <= 1'b1;
            if (!bus_we) d_rdata <= bus_rdata;
          end else begin
            if_ack   <= 1'b1;
            if_rdata <= bus_rdata;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: transaction-level model for WAIT_CYCLES=2,
// plus access-width checks on WAIT_CYCLES=1 and WAIT_CYCLES=15 instances.
module tb_mem_arbiter;

  localparam int W = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, d_req, d_we;
  logic [31:0] if_addr, d_addr, d_wdata, bus_rdata;
  logic [3:0]  d_be;
  logic [31:0] if_rdata, d_rdata, bus_addr, bus_wdata;
  logic        if_ack, d_ack, bus_en, bus_we, grant_d;
  logic [3:0]  bus_be;

  logic        d_req_off;
  logic        x_req [2];
  logic [31:0] x_if_rdata [2], x_d_rdata [2], x_addr [2], x_wdata [2];
  logic        x_if_ack [2], x_d_ack [2], x_en [2], x_we [2], x_gd [2];
  logic [3:0]  x_be [2];

  int n_chk  = 0;
  int n_fail = 0;

  assign d_req_off = 1'b0;

  always #5 clk = ~clk;

  mem_arbiter #(.WAIT_CYCLES(W)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ack(d_ack),
    .bus_en(bus_en), .bus_we(bus_we), .bus_be(bus_be), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .grant_d(grant_d)
  );

  mem_arbiter #(.WAIT_CYCLES(1)) dut_w1 (
    .clk(clk), .rst(rst),
    .if_req(x_req[0]), .if_addr(if_addr), .if_rdata(x_if_rdata[0]), .if_ack(x_if_ack[0]),
    .d_req(d_req_off), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(x_d_rdata[0]), .d_ack(x_d_ack[0]),
    .bus_en(x_en[0]), .bus_we(x_we[0]), .bus_be(x_be[0]), .bus_addr(x_addr[0]),
    .bus_wdata(x_wdata[0]), .bus_rdata(bus_rdata), .grant_d(x_gd[0])
  );

  mem_arbiter #(.WAIT_CYCLES(15)) dut_w15 (
    .clk(clk), .rst(rst),
    .if_req(x_req[1]), .if_addr(if_addr), .if_rdata(x_if_rdata[1]), .if_ack(x_if_ack[1]),
    .d_req(d_req_off), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(x_d_rdata[1]), .d_ack(x_d_ack[1]),
    .bus_en(x_en[1]), .bus_we(x_we[1]), .bus_be(x_be[1]), .bus_addr(x_addr[1]),
    .bus_wdata(x_wdata[1]), .bus_rdata(bus_rdata), .grant_d(x_gd[1])
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: an access granted at edge k completes (ack, rdata capture) at edge k+W.
  int          cyc;
  int          m_done;
  bit          m_busy;
  logic        m_en, m_we, m_gd, m_if_ack, m_d_ack;
  logic [3:0]  m_be;
  logic [31:0] m_addr, m_wdata, m_if_rdata, m_d_rdata;

  task automatic model_reset();
    cyc = 0; m_done = 0; m_busy = 0;
    m_en = 0; m_we = 0; m_gd = 0; m_if_ack = 0; m_d_ack = 0;
    m_be = '0; m_addr = '0; m_wdata = '0; m_if_rdata = '0; m_d_rdata = '0;
  endtask

  task automatic model_step();
    logic nia, nda;
    nia = 1'b0;
    nda = 1'b0;
    cyc++;
    if (m_busy) begin
      if (cyc == m_done) begin
        m_busy = 0;
        m_en = 1'b0;
        if (m_gd) begin
          nda = 1'b1;
          if (!m_we) m_d_rdata = bus_rdata;
        end else begin
          nia = 1'b1;
          m_if_rdata = bus_rdata;
        end
        m_we = 1'b0;
      end
    end else if (d_req && !m_d_ack) begin
      m_busy = 1; m_done = cyc + W; m_en = 1'b1; m_gd = 1'b1;
      m_we = d_we; m_be = d_be; m_addr = d_addr; m_wdata = d_wdata;
    end else if (if_req && !m_if_ack) begin
      m_busy = 1; m_done = cyc + W; m_en = 1'b1; m_gd = 1'b0;
      m_we = 1'b0; m_be = 4'hF; m_addr = if_addr; m_wdata = '0;
    end
    m_if_ack = nia;
    m_d_ack  = nda;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) model_reset();
      else     model_step();
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("bus_en",    {31'd0, bus_en},  {31'd0, m_en});
      chk("bus_we",    {31'd0, bus_we},  {31'd0, m_we});
      chk("bus_be",    {28'd0, bus_be},  {28'd0, m_be});
      chk("bus_addr",  bus_addr,         m_addr);
      chk("bus_wdata", bus_wdata,        m_wdata);
      chk("grant_d",   {31'd0, grant_d}, {31'd0, m_gd});
      chk("if_ack",    {31'd0, if_ack},  {31'd0, m_if_ack});
      chk("d_ack",     {31'd0, d_ack},   {31'd0, m_d_ack});
      chk("if_rdata",  if_rdata,         m_if_rdata);
      chk("d_rdata",   d_rdata,          m_d_rdata);
      chk("ack_excl",  {31'd0, if_ack & d_ack}, 32'd0);
    end
  end

  task automatic measure(input int sel, input int w);
    int n, t;
    @(negedge clk);
    x_req[sel] = 1'b1;
    t = 0;
    while (x_en[sel] !== 1'b1 && t < 5) begin @(negedge clk); t++; end
    chk($sformatf("w%0d_addr", w), x_addr[sel], if_addr);
    chk($sformatf("w%0d_be", w), {28'd0, x_be[sel]}, 32'hF);
    n = 0;
    while (x_en[sel] === 1'b1 && n < 40) begin
      chk($sformatf("w%0d_we", w), {31'd0, x_we[sel]}, 32'd0);
      @(negedge clk);
      n++;
    end
    chk($sformatf("w%0d_en_width", w), n, w);
    chk($sformatf("w%0d_ack", w), {31'd0, x_if_ack[sel]}, 32'd1);
    chk($sformatf("w%0d_rdata", w), x_if_rdata[sel], bus_rdata);
    chk($sformatf("w%0d_d_ack", w), {31'd0, x_d_ack[sel]}, 32'd0);
    chk($sformatf("w%0d_grant_d", w), {31'd0, x_gd[sel]}, 32'd0);
    chk($sformatf("w%0d_wdata", w), x_wdata[sel], 32'd0);
    chk($sformatf("w%0d_d_rdata", w), x_d_rdata[sel], 32'd0);
    x_req[sel] = 1'b0;
    @(negedge clk);
    chk($sformatf("w%0d_ack_clear", w), {31'd0, x_if_ack[sel]}, 32'd0);
    repeat (3) begin
      chk($sformatf("w%0d_en_idle", w), {31'd0, x_en[sel]}, 32'd0);
      @(negedge clk);
    end
  endtask

  int ack_pos [3];
  int n_acks;

  initial begin
    rst = 1'b1;
    if_req = 0; d_req = 0; d_we = 0; d_be = '0;
    if_addr = '0; d_addr = '0; d_wdata = '0; bus_rdata = '0;
    x_req[0] = 0; x_req[1] = 0;
    repeat (2) @(negedge clk);
    chk("rst_bus_en",   {31'd0, bus_en},  32'd0);
    chk("rst_if_ack",   {31'd0, if_ack},  32'd0);
    chk("rst_d_ack",    {31'd0, d_ack},   32'd0);
    chk("rst_grant_d",  {31'd0, grant_d}, 32'd0);
    chk("rst_bus_addr", bus_addr,         32'd0);
    chk("rst_bus_be",   {28'd0, bus_be},  32'd0);
    chk("rst_if_rdata", if_rdata,         32'd0);
    chk("rst_d_rdata",  d_rdata,          32'd0);

    // Single fetch
    rst = 1'b0;
    if_req = 1; if_addr = 32'h8000_0000; bus_rdata = 32'h2402_0005;
    @(negedge clk);
    chk("t1_en",   {31'd0, bus_en}, 32'd1);
    chk("t1_addr", bus_addr,        32'h8000_0000);
    chk("t1_we",   {31'd0, bus_we}, 32'd0);
    chk("t1_be",   {28'd0, bus_be}, 32'hF);
    @(negedge clk);
    chk("t1_en2",  {31'd0, bus_en}, 32'd1);
    @(negedge clk);
    chk("t1_en_off", {31'd0, bus_en}, 32'd0);
    chk("t1_ack",    {31'd0, if_ack}, 32'd1);
    chk("t1_rdata",  if_rdata,        32'h2402_0005);
    chk("t1_d_ack",  {31'd0, d_ack},  32'd0);
    if_req = 0;
    @(negedge clk);
    chk("t1_ack_clr", {31'd0, if_ack}, 32'd0);

    // Simultaneous requests: data first, fetch on the edge after d_ack rises
    if_req = 1; if_addr = 32'h0000_0100;
    d_req = 1; d_we = 0; d_be = 4'hF; d_addr = 32'h0000_0010; bus_rdata = 32'h1111_2222;
    @(negedge clk);
    chk("t2_grant_d", {31'd0, grant_d}, 32'd1);
    chk("t2_addr",    bus_addr,         32'h0000_0010);
    @(negedge clk);
    @(negedge clk);
    chk("t2_d_ack",   {31'd0, d_ack},  32'd1);
    chk("t2_d_rdata", d_rdata,         32'h1111_2222);
    chk("t2_if_ack0", {31'd0, if_ack}, 32'd0);
    d_req = 0; bus_rdata = 32'h3333_4444;
    @(negedge clk);
    chk("t2_grant_f", {31'd0, grant_d}, 32'd0);
    chk("t2_f_addr",  bus_addr,         32'h0000_0100);
    chk("t2_f_en",    {31'd0, bus_en},  32'd1);
    @(negedge clk);
    @(negedge clk);
    chk("t2_if_ack",  {31'd0, if_ack}, 32'd1);
    chk("t2_if_data", if_rdata,        32'h3333_4444);
    if_req = 0;
    @(negedge clk);

    // Data write
    d_req = 1; d_we = 1; d_be = 4'b0011; d_addr = 32'h0000_0020; d_wdata = 32'hDEAD_BEEF;
    bus_rdata = 32'h5555_6666;
    @(negedge clk);
    chk("t3_we",    {31'd0, bus_we}, 32'd1);
    chk("t3_be",    {28'd0, bus_be}, 32'h3);
    chk("t3_addr",  bus_addr,        32'h0000_0020);
    chk("t3_wdata", bus_wdata,       32'hDEAD_BEEF);
    @(negedge clk);
    chk("t3_we2",   {31'd0, bus_we}, 32'd1);
    @(negedge clk);
    chk("t3_we_off",  {31'd0, bus_we}, 32'd0);
    chk("t3_d_ack",   {31'd0, d_ack},  32'd1);
    chk("t3_d_rdata", d_rdata,         32'h1111_2222);
    d_req = 0; d_we = 0;
    @(negedge clk);

    // Held fetch request: three acks four cycles apart
    if_req = 1; if_addr = 32'h0000_0200;
    n_acks = 0;
    ack_pos[0] = -1; ack_pos[1] = -1; ack_pos[2] = -1;
    for (int c = 1; c <= 11; c++) begin
      @(negedge clk);
      if (if_ack === 1'b1) begin
        if (n_acks < 3) ack_pos[n_acks] = c;
        n_acks++;
      end
      if (c == 11) if_req = 0;
    end
    chk("t4_n_acks", n_acks,     32'd3);
    chk("t4_ack0",   ack_pos[0], 32'd3);
    chk("t4_ack1",   ack_pos[1], 32'd7);
    chk("t4_ack2",   ack_pos[2], 32'd11);
    @(negedge clk);

    // Asynchronous reset during the first access cycle
    if_req = 1; if_addr = 32'h0000_0300;
    @(negedge clk);
    chk("t5_en_pre", {31'd0, bus_en}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("t5_en_async", {31'd0, bus_en}, 32'd0);
    chk("t5_ack_async", {31'd0, if_ack}, 32'd0);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("t5_restart_en", {31'd0, bus_en}, 32'd1);
    chk("t5_no_ack1",    {31'd0, if_ack}, 32'd0);
    @(negedge clk);
    chk("t5_no_ack2",    {31'd0, if_ack}, 32'd0);
    @(negedge clk);
    chk("t5_ack",        {31'd0, if_ack}, 32'd1);
    if_req = 0;
    @(negedge clk);

    // Access width on the WAIT_CYCLES=1 and WAIT_CYCLES=15 builds
    if_addr = 32'h0000_0400; bus_rdata = 32'hA5A5_0001;
    measure(0, 1);
    bus_rdata = 32'hA5A5_000F;
    measure(1, 15);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1);
  end

endmodule
